seq_detector_jk: RTL and testbench
==================================

Name: seq_detector_jk

Overview:
- Parametrised serial pattern detector; successor to the fixed 3-bit JK-flip-flop machines in the sequential-logic block set.
- Samples one serial bit `x` per enabled clock and tracks how much of a configurable PATTERN has been matched.
- Pulses `F` on each complete match and keeps a saturating match count.
- The state register is built from JK cells, with J/K excitation derived from the next-state logic, so the design stays in the JK-machine style.

Parameters:
- N, 4, pattern length in bits; legal range 1..16.
- PATTERN, 4'b1101, N-bit target pattern; PATTERN[N-1] is the first bit received, PATTERN[0] the last.
- OVERLAP, 1, 1 = overlapping matches allowed (KMP fallback after a match); 0 = restart from empty after a match.
- COUNT_W, 8, width of the match counter.
- SW, derived, state width = (N>1) ? $clog2(N) : 1; not user-set.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  sample enable; `x` is consumed only when EN=1.
- x  input  1  serial data bit.
- CLR  input  1  synchronous clear of COUNT only.
- F  output  1  registered match pulse.
- S  output  SW  current state = number of PATTERN bits matched so far (0..N-1).
- COUNT  output  COUNT_W  saturating count of matches.

Behaviour:
- Reset: all actions on a rising CLK edge.
  - RESET=1 gives S=0, F=0, COUNT=0 on the next edge.
  - RESET overrides EN, CLR and x.
  - RESET mid-pattern discards partial progress.
- State meaning: S=k means the last k consumed bits equal PATTERN[N-1 -: k]. The full-match state N is never held.
- Transition on an edge with EN=1:
  - If x == PATTERN[N-1-S] and S < N-1: S <= S+1.
  - If x == PATTERN[0] and S == N-1 (full match):
    - F <= 1 and COUNT increments.
    - OVERLAP=1: S <= longest proper prefix of PATTERN that is also a suffix of PATTERN.
    - OVERLAP=0: S <= 0.
  - On mismatch: S <= largest j < S+1 such that the last j bits (including x) equal PATTERN[N-1 -: j]. This can be nonzero, e.g. "111" against 1101 gives S=2.
- Fallback table: computed at elaboration by a constant function over PATTERN; no runtime table.
- F pulse rules:
  - F is high for exactly one cycle, the cycle after the edge that sampled the final matching bit.
  - Back-to-back matches give consecutive F pulses.
  - F=0 on every edge where EN=0.
- EN=0: S and COUNT hold, F <= 0, and x is ignored.
- COUNT:
  - Increments by 1 per match and saturates at 2^COUNT_W-1 with no wrap.
  - CLR=1 gives COUNT <= 0.
  - CLR takes priority over a simultaneous match; F still pulses.
- JK state cells, per bit i:
  - J_i = next_i & ~q_i, K_i = ~next_i & q_i.
  - Synchronous RESET forces q_i=0.
- Latency: one cycle from final bit sample to F. COUNT updates on the same edge F rises.
- N=1: S is constant 0, F=1 after every enabled edge with x==PATTERN[0], and OVERLAP has no effect.

Decomposition:
- Shared package `seq_fsm_pkg`:
  - constant function `kmp_fallback(pattern, n, k, bit)` returning the next state.
  - constant function `state_width(n)`.
- Sub-module `jkff_reg #(W)`: W JK cells with shared CLK and synchronous active-high RESET, vector J/K in, Q out. It is used for the S register.
- COUNT and F are plain registers in the top level.

Test Plan:
- Reset: RESET=1 for 2 cycles with x toggling and EN=1 → S=0, F=0, COUNT=0. Then RESET=1 after stream 1,1,0 → S=0, and a following 1 gives no F.
- Basic match (PATTERN=1101, OVERLAP=1): stream 1,1,0,1 → S=1,2,3,1. F=1 only in the cycle after bit 4, and COUNT=1.
- Overlap vs non-overlap: stream 1,1,0,1,1,0,1.
  - OVERLAP=1: F pulses after bits 4 and 7, COUNT=2.
  - OVERLAP=0: a single F after bit 4, COUNT=1, and S=1 after bit 7.
- Fallback: stream 1,1,1,0,1 → S=1,2,2,3 and F after bit 5. Stream 1,1,0,0 → S returns to 0 after bit 4.
- Enable gating: stream 1,1 with EN=1, then 4 cycles EN=0 with x=0, then 0,1 with EN=1 → S holds at 2 during the stall, F=0 during the stall, F pulses after the final 1.
- Saturation and clear (COUNT_W=2): 4 consecutive matches → COUNT goes 1,2,3,3. Assert CLR on the edge of a 5th match → COUNT=0 and F=1 on that same cycle.

Source files
------------

// File: rtl/seq_fsm_pkg.sv
// Elaboration-time helpers for serial pattern detectors: state-register width
// and the KMP-style next-state function evaluated over a constant pattern.
package seq_fsm_pkg;

  localparam int MAX_N = 16;

  function automatic int state_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Longest j < n such that the last j bits of (PATTERN[n-1 -: k], b) equal
  // PATTERN[n-1 -: j]. This covers advancing, mismatch fallback, and the
  // overlapping restart after a full match.
  function automatic int kmp_fallback(input logic [MAX_N-1:0] pattern, input int n,
                                      input int k, input logic b);
    int best;
    int lim;
    int idx;
    logic ok;
    logic sb;
    best = 0;
    lim  = (k + 1 < n) ? k + 1 : n - 1;
    for (int j = 1; j <= MAX_N; j++) begin
      if (j <= lim) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_N; t++) begin
          if (t < j) begin
            idx = k + 1 - j + t;
            if (idx == k) sb = b;
            else          sb = pattern[n-1-idx];
            if (sb != pattern[n-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/jkff_reg.sv
// Vector of JK flip-flops sharing one clock and a synchronous active-high reset.
module jkff_reg #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] J,
  input  logic [W-1:0] K,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RESET) Q <= '0;
    else       Q <= (J & ~Q) | (~K & Q);
  end

endmodule

// File: rtl/seq_detector_jk.sv
// Parametrised serial pattern detector with a JK-cell state register, a
// registered match pulse and a saturating, clearable match counter.
module seq_detector_jk
  import seq_fsm_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             OVERLAP = 1,
  parameter int             COUNT_W = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        EN,
  input  logic                        x,
  input  logic                        CLR,
  output logic                        F,
  output logic [state_width(N)-1:0]   S,
  output logic [COUNT_W-1:0]          COUNT
);

  localparam int                 SW      = state_width(N);
  localparam int                 NS      = 2 ** SW;
  localparam logic [SW-1:0]      LAST    = SW'(N - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Next-state table fixed at elaboration; unreachable codes fall back to 0.
  logic [SW-1:0] fb_tbl [NS][2];

  generate
    for (genvar st = 0; st < NS; st++) begin : g_st
      for (genvar bv = 0; bv < 2; bv++) begin : g_bit
        if (st < N) begin : g_live
          assign fb_tbl[st][bv] = SW'(kmp_fallback(MAX_N'(PATTERN), N, st, 1'(bv)));
        end else begin : g_dead
          assign fb_tbl[st][bv] = '0;
        end
      end
    end
  endgenerate

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_nxt;
  logic [SW-1:0] jset;
  logic [SW-1:0] kclr;
  logic          match;

  always_comb begin
    match = 1'b0;
    s_nxt = s_q;
    if (EN) begin
      match = (s_q == LAST) && (x == PATTERN[0]);
      if (match && OVERLAP == 0) s_nxt = '0;
      else                       s_nxt = fb_tbl[s_q][x];
    end
  end

  assign jset = s_nxt & ~s_q;
  assign kclr = ~s_nxt & s_q;

  jkff_reg #(.W(SW)) u_state (
    .CLK   (CLK),
    .RESET (RESET),
    .J     (jset),
    .K     (kclr),
    .Q     (s_q)
  );

  assign S = s_q;

  // CLR wins over a coincident match; the pulse on F is unaffected by it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      F     <= 1'b0;
      COUNT <= '0;
    end else begin
      F <= match;
      if (CLR)                             COUNT <= '0;
      else if (match && COUNT != CNT_MAX)  COUNT <= COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_jk.sv
// Bench for seq_detector_jk: directed scenarios plus randomized traffic
// against a history-based reference model of the detector.
module tb_seq_detector_jk;

  localparam int           N   = 4;
  localparam logic [N-1:0] PAT = 4'b1101;

  logic CLK = 1'b0;
  logic RESET = 1'b1, EN = 1'b0, x = 1'b0, CLR = 1'b0;
  logic F_a, F_b, F_c, F_d;
  logic [1:0] S_a, S_b, S_c;
  logic [0:0] S_d;
  logic [7:0] COUNT_a, COUNT_b, COUNT_d;
  logic [1:0] COUNT_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: recent consumed bits (newest at bit 0) and their count.
  logic [31:0] hv_a = '0, hv_b = '0;
  int hl_a = 0, hl_b = 0;
  logic ef_a = 0, ef_b = 0, ef_d = 0;
  int ec_a = 0, ec_b = 0, ec_c = 0, ec_d = 0;

  seq_detector_jk #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .COUNT_W(8)) dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR), .F(F_a), .S(S_a), .COUNT(COUNT_a));
  seq_detector_jk #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .COUNT_W(8)) dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR), .F(F_b), .S(S_b), .COUNT(COUNT_b));
  seq_detector_jk #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .COUNT_W(2)) dut_c (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR), .F(F_c), .S(S_c), .COUNT(COUNT_c));
  seq_detector_jk #(.N(1), .PATTERN(1'b1), .OVERLAP(1), .COUNT_W(8)) dut_d (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR), .F(F_d), .S(S_d), .COUNT(COUNT_d));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int state_of(input logic [31:0] hv, input int hl);
    int best;
    logic ok;
    best = 0;
    for (int j = 1; j < N; j++) begin
      if (j <= hl) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) if (hv[j-1-t] !== PAT[N-1-t]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic logic full_of(input logic [31:0] hv, input int hl);
    if (hl < N) return 1'b0;
    for (int t = 0; t < N; t++) if (hv[N-1-t] !== PAT[N-1-t]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic e, input logic xb, input logic c, input logic r);
    logic ma, mb, md;
    ma = 1'b0; mb = 1'b0; md = 1'b0;
    if (r) begin
      hl_a = 0; hl_b = 0; hv_a = '0; hv_b = '0;
      ef_a = 0; ef_b = 0; ef_d = 0;
      ec_a = 0; ec_b = 0; ec_c = 0; ec_d = 0;
    end else begin
      if (e) begin
        hv_a = {hv_a[30:0], xb}; if (hl_a < N) hl_a++;
        hv_b = {hv_b[30:0], xb}; if (hl_b < N) hl_b++;
        ma = full_of(hv_a, hl_a);
        mb = full_of(hv_b, hl_b);
        if (mb) hl_b = 0;
        md = xb;
      end
      ef_a = ma; ef_b = mb; ef_d = md;
      ec_a = c ? 0 : ((ma && ec_a < 255) ? ec_a + 1 : ec_a);
      ec_b = c ? 0 : ((mb && ec_b < 255) ? ec_b + 1 : ec_b);
      ec_c = c ? 0 : ((ma && ec_c < 3)   ? ec_c + 1 : ec_c);
      ec_d = c ? 0 : ((md && ec_d < 255) ? ec_d + 1 : ec_d);
    end
  endtask

  task automatic step(input logic e, input logic xb, input logic c, input logic r);
    EN = e; x = xb; CLR = c; RESET = r;
    @(posedge CLK);
    model_edge(e, xb, c, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'(i), 1'b0, 1'b1);
      n_tests++;
      if (S_a !== 2'd0 || F_a !== 1'b0 || COUNT_a !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: got S=%0d F=%0d COUNT=%0d expected S=0 F=0 COUNT=0",
                 i, S_a, F_a, COUNT_a);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (S_a !== 2'd0) begin
      n_fail++; $display("FAIL reset_midpattern_S: got %0d expected 0", S_a);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (F_a !== 1'b0 || S_a !== 2'd1) begin
      n_fail++; $display("FAIL reset_no_resume: got F=%0d S=%0d expected F=0 S=1", F_a, S_a);
    end
  endtask

  task automatic test_basic_match();
    logic [3:0] str;
    int es[4];
    es[0] = 1; es[1] = 2; es[2] = 3; es[3] = 1;
    str = 4'b1101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, str[3-i], 1'b0, 1'b0);
      n_tests++;
      if (S_a !== 2'(es[i]) || F_a !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_bit%0d: got S=%0d F=%0d expected S=%0d F=%0d", i + 1, S_a, F_a, es[i], (i == 3));
      end
    end
    n_tests++;
    if (COUNT_a !== 8'd1) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 1", COUNT_a);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (F_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse_width: got F=%0d expected 0", F_a);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] str;
    str = 7'b1101101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, str[6-i], 1'b0, 1'b0);
      n_tests++;
      if (F_a !== (i == 3 || i == 6) || F_b !== (i == 3)) begin
        n_fail++;
        $display("FAIL overlap_F bit%0d: got Fov=%0d Fno=%0d expected Fov=%0d Fno=%0d",
                 i + 1, F_a, F_b, (i == 3 || i == 6), (i == 3));
      end
    end
    n_tests++;
    if (COUNT_a !== 8'd2 || COUNT_b !== 8'd1 || S_b !== 2'd1) begin
      n_fail++;
      $display("FAIL overlap_final: got COUNTov=%0d COUNTno=%0d Sno=%0d expected 2 1 1",
               COUNT_a, COUNT_b, S_b);
    end
  endtask

  task automatic test_fallback();
    logic [4:0] str;
    logic [3:0] str2;
    int es[4];
    es[0] = 1; es[1] = 2; es[2] = 2; es[3] = 3;
    str = 5'b11101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, str[4-i], 1'b0, 1'b0);
      n_tests++;
      if ((i < 4 && S_a !== 2'(es[i])) || F_a !== (i == 4)) begin
        n_fail++;
        $display("FAIL fallback_bit%0d: got S=%0d F=%0d expected S=%0d F=%0d",
                 i + 1, S_a, F_a, (i < 4) ? es[i] : 1, (i == 4));
      end
    end
    str2 = 4'b1100;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, str2[3-i], 1'b0, 1'b0);
    n_tests++;
    if (S_a !== 2'd0) begin
      n_fail++; $display("FAIL fallback_to_zero: got S=%0d expected 0", S_a);
    end
  endtask

  task automatic test_enable();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (S_a !== 2'd2 || F_a !== 1'b0) begin
        n_fail++; $display("FAIL enable_stall cyc%0d: got S=%0d F=%0d expected S=2 F=0", i, S_a, F_a);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (S_a !== 2'd3 || F_a !== 1'b0) begin
      n_fail++; $display("FAIL enable_resume: got S=%0d F=%0d expected S=3 F=0", S_a, F_a);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (F_a !== 1'b1 || COUNT_a !== 8'd1) begin
      n_fail++; $display("FAIL enable_match: got F=%0d COUNT=%0d expected F=1 COUNT=1", F_a, COUNT_a);
    end
  endtask

  task automatic test_saturation();
    int ec[4];
    ec[0] = 1; ec[1] = 2; ec[2] = 3; ec[3] = 3;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (COUNT_c !== 2'(ec[m]) || F_c !== 1'b1) begin
        n_fail++; $display("FAIL sat_match%0d: got COUNT=%0d F=%0d expected COUNT=%0d F=1", m + 1, COUNT_c, F_c, ec[m]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (COUNT_c !== 2'd0 || F_c !== 1'b1) begin
      n_fail++; $display("FAIL sat_clear: got COUNT=%0d F=%0d expected COUNT=0 F=1", COUNT_c, F_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] str;
    str = 4'b1101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, str[3-i], 1'b0, 1'b0);
      n_tests++;
      if (F_d !== str[3-i] || S_d !== 1'b0) begin
        n_fail++; $display("FAIL b2b_n1 bit%0d: got F=%0d S=%0d expected F=%0d S=0", i + 1, F_d, S_d, str[3-i]);
      end
    end
    n_tests++;
    if (COUNT_d !== 8'd3) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 3", COUNT_d);
    end
  endtask

  task automatic test_random();
    logic e, xb, c, r;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(3) != 0);
      xb = 1'($urandom_range(1));
      c  = ($urandom_range(29) == 0);
      r  = ($urandom_range(79) == 0);
      step(e, xb, c, r);
      n_tests++;
      if (S_a !== 2'(state_of(hv_a, hl_a)) || F_a !== ef_a || COUNT_a !== 8'(ec_a)) begin
        n_fail++;
        $display("FAIL rand_ov cyc%0d: got S=%0d F=%0d C=%0d expected S=%0d F=%0d C=%0d",
                 i, S_a, F_a, COUNT_a, state_of(hv_a, hl_a), ef_a, ec_a);
      end
      n_tests++;
      if (S_b !== 2'(state_of(hv_b, hl_b)) || F_b !== ef_b || COUNT_b !== 8'(ec_b)) begin
        n_fail++;
        $display("FAIL rand_no cyc%0d: got S=%0d F=%0d C=%0d expected S=%0d F=%0d C=%0d",
                 i, S_b, F_b, COUNT_b, state_of(hv_b, hl_b), ef_b, ec_b);
      end
      n_tests++;
      if (S_c !== 2'(state_of(hv_a, hl_a)) || F_c !== ef_a || COUNT_c !== 2'(ec_c)) begin
        n_fail++;
        $display("FAIL rand_sat cyc%0d: got S=%0d F=%0d C=%0d expected S=%0d F=%0d C=%0d",
                 i, S_c, F_c, COUNT_c, state_of(hv_a, hl_a), ef_a, ec_c);
      end
      n_tests++;
      if (S_d !== 1'b0 || F_d !== ef_d || COUNT_d !== 8'(ec_d)) begin
        n_fail++;
        $display("FAIL rand_n1 cyc%0d: got S=%0d F=%0d C=%0d expected S=0 F=%0d C=%0d",
                 i, S_d, F_d, COUNT_d, ef_d, ec_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_overlap();
    test_fallback();
    test_enable();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
